winograd_tile_loader: RTL and testbench

Streaming tile builder placed directly upstream of the Winograd feature-transform mesh. Accepts input-feature-map columns (4 rows tall, MESH_N channels wide) one beat at a time, keeps a 4-column sliding window, and emits overlapping 4x4 tiles with stride 2 per Winograd F(2,3). The output word is packed exactly as the feature mesh's `feature` input expects. A registered valid/ready output absorbs downstream backpressure.

---
 rtl/winograd_tile_loader.sv | 81 ++++++++
 tb/tb_winograd_tile_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/winograd_tile_loader.sv
// winograd_tile_loader: builds overlapping 4x4 stride-2 Winograd F(2,3) tiles from a stream of 4-row columns
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     column handshake; in_col packs channel i row r at [DATA_BIT*(4*i+r)]
//   out_valid/out_ready   tile handshake; out_tile packs channel i element (r,c) at [DATA_BIT*(16*i+4*r+c)]
//   out_last              final tile of a tile-row
//   out_idx               tile index within its row, present only with TILE_LOADER_IDX_EN defined
module winograd_tile_loader #(
    parameter int FEATURE_SIZE = 4,
    parameter int DATA_BIT     = 8,
    parameter int MESH_N       = 8,
    parameter int IMG_W        = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [MESH_N*4*DATA_BIT-1:0]           in_col,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MESH_N*16*DATA_BIT-1:0]          out_tile,
    output logic                                   out_last
`ifdef TILE_LOADER_IDX_EN
    ,
    output logic [$clog2(IMG_W)-1:0]               out_idx
`endif
);
    localparam int CW = MESH_N * FEATURE_SIZE * DATA_BIT;
    localparam int CB = $clog2(IMG_W);
    typedef enum logic {FILL, STREAM} state_t;
    state_t state;
    logic [CW-1:0] win [4];
    logic [CW-1:0] nwin [4];
    logic [CB-1:0] col;
    logic [MESH_N*16*DATA_BIT-1:0] tile_next;
    logic next_is_tile, last_col, accept;
    // In STREAM col is at least 3, so an odd col is always a tile event
    assign next_is_tile = (state == STREAM) && col[0];
    assign last_col     = col == CB'(IMG_W - 1);
    assign in_ready     = !(next_is_tile && out_valid && !out_ready);
    assign accept       = in_valid && in_ready;
    // Window as it will look after this cycle's shift; tiles are cut from it
    assign nwin[0] = win[1];
    assign nwin[1] = win[2];
    assign nwin[2] = win[3];
    assign nwin[3] = in_col;
    for (genvar i = 0; i < MESH_N; i++) begin : g_ch
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < 4; c++) begin : g_col
                assign tile_next[DATA_BIT*(16*i+4*r+c) +: DATA_BIT] = nwin[c][DATA_BIT*(4*i+r) +: DATA_BIT];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            col       <= '0;
            state     <= FILL;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_tile  <= '0;
`ifdef TILE_LOADER_IDX_EN
            out_idx   <= '0;
`endif
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 4; i++) win[i] <= nwin[i];
                col   <= last_col ? '0 : col + 1'b1;
                state <= last_col ? FILL : (col == CB'(2) ? STREAM : state);
                if (next_is_tile) begin
                    out_valid <= 1'b1;
                    out_tile  <= tile_next;
                    out_last  <= last_col;
`ifdef TILE_LOADER_IDX_EN
                    out_idx   <= (col - CB'(3)) >> 1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_winograd_tile_loader.sv
// tb_winograd_tile_loader: directed self-checking bench for winograd_tile_loader (IMG_W=8, MESH_N=2, DATA_BIT=8)
module tb_winograd_tile_loader;
    localparam int DB = 8;
    localparam int MN = 2;
    localparam int IW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [MN*4*DB-1:0] in_col = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [MN*16*DB-1:0] out_tile;
    logic out_last;
`ifdef TILE_LOADER_IDX_EN
    logic [2:0] out_idx;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    winograd_tile_loader #(.FEATURE_SIZE(4), .DATA_BIT(DB), .MESH_N(MN), .IMG_W(IW)) dut (
`ifdef TILE_LOADER_IDX_EN
        .out_idx(out_idx),
`endif
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile), .out_last(out_last)
    );
    function automatic logic [MN*4*DB-1:0] colw(input int g);
        logic [MN*4*DB-1:0] w;
        w = '0;
        for (int ch = 0; ch < MN; ch++)
            for (int r = 0; r < 4; r++)
                w[DB*(4*ch+r) +: DB] = 8'(16*ch + 8*g + r);
        return w;
    endfunction
    // Tile whose leftmost column is global column s: element (r,c) = 16*ch + 8*(s+c) + r
    function automatic logic [MN*16*DB-1:0] expt(input int s);
        logic [MN*16*DB-1:0] t;
        t = '0;
        for (int ch = 0; ch < MN; ch++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[DB*(16*ch+4*r+c) +: DB] = 8'(16*ch + 8*(s+c) + r);
        return t;
    endfunction
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    // Streams n columns with out_ready high, optionally with an idle cycle after each column
    task automatic run_row(input int n, input bit bubble, input string nm);
        for (int g = 0; g < n; g++) begin
            int lg;
            bit ev;
            lg = g % IW;
            ev = (lg % 2 == 1) && (lg >= 3);
            in_valid = 1'b1;
            in_col = colw(g);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready col %0d: got %b want 1", nm, g, in_ready); end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== ev) begin n_bad++; $display("FAIL %s out_valid col %0d: got %b want %b", nm, g, out_valid, ev); end
            if (ev) begin
                n_cmp++;
                if (out_tile !== expt(g - 3)) begin n_bad++; $display("FAIL %s out_tile col %0d: got %h want %h", nm, g, out_tile, expt(g - 3)); end
                n_cmp++;
                if (out_last !== (lg == IW - 1)) begin n_bad++; $display("FAIL %s out_last col %0d: got %b want %b", nm, g, out_last, lg == IW - 1); end
`ifdef TILE_LOADER_IDX_EN
                n_cmp++;
                if (out_idx !== 3'((lg - 3) / 2)) begin n_bad++; $display("FAIL %s out_idx col %0d: got %0d want %0d", nm, g, out_idx, (lg - 3) / 2); end
`endif
            end
            if (bubble) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s bubble out_valid col %0d: got %b want 0", nm, g, out_valid); end
            end
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
        n_cmp++;
        if (out_tile !== '0) begin n_bad++; $display("FAIL reset out_tile: got %h want 0", out_tile); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask
    task automatic test_streaming();
        do_reset();
        run_row(8, 1'b0, "stream");
    endtask
    task automatic test_multi_row();
        do_reset();
        run_row(16, 1'b0, "multirow");
    endtask
    task automatic test_bubbles();
        do_reset();
        run_row(8, 1'b1, "bubble");
    endtask
    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            in_valid = 1'b1;
            in_col = colw(g);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp in_ready col %0d: got %b want 1", g, in_ready); end
            @(posedge clk);
            #1;
        end
        in_col = colw(5);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp stall in_ready: got %b want 0", in_ready); end
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp hold out_valid: got %b want 1", out_valid); end
            n_cmp++;
            if (out_tile !== expt(0)) begin n_bad++; $display("FAIL bp hold out_tile: got %h want %h", out_tile, expt(0)); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp swap out_valid: got %b want 1", out_valid); end
        n_cmp++;
        if (out_tile !== expt(2)) begin n_bad++; $display("FAIL bp swap out_tile: got %h want %h", out_tile, expt(2)); end
        n_cmp++;
        if (out_last !== 1'b0) begin n_bad++; $display("FAIL bp swap out_last: got %b want 0", out_last); end
        in_col = colw(6);
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp col6 out_valid: got %b want 0", out_valid); end
        in_col = colw(7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_tile !== expt(4)) begin n_bad++; $display("FAIL bp tile2 out_tile: got %h want %h", out_tile, expt(4)); end
        n_cmp++;
        if (out_last !== 1'b1) begin n_bad++; $display("FAIL bp tile2 out_last: got %b want 1", out_last); end
    endtask
    task automatic test_reset_mid_row();
        do_reset();
        out_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            in_valid = 1'b1;
            in_col = colw(g);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst pending out_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_tile !== '0) begin n_bad++; $display("FAIL midrst out_tile: got %h want 0", out_tile); end
        n_cmp++;
        if (out_last !== 1'b0) begin n_bad++; $display("FAIL midrst out_last: got %b want 0", out_last); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        run_row(8, 1'b0, "midrst_fresh");
    endtask
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_multi_row();
        test_bubbles();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
